// File: rtl/pipe_ctrl_seq.sv
// Pipeline control sequencer: PC source selection, stage-buffer enable/flush,
// load-use stall, branch flush and the multi-cycle interrupt entry/RTI exit.
module pipe_ctrl_seq #(
    parameter int RESET_CYCLES = 2,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       int_req,
    input  logic [2:0] id_rsrc1,
    input  logic [2:0] id_rsrc2,
    input  logic       id_use1,
    input  logic       id_use2,
    input  logic       ex_mem_read,
    input  logic       ex_wb,
    input  logic [2:0] ex_rdst,
    input  logic       ex_branch_taken,
    input  logic       mem_rti,
    input  logic       mem_busy,
    output logic [1:0] pc_select,
    output logic       fetch_en,
    output logic       fd_en,
    output logic       fd_flush,
    output logic       de_flush,
    output logic       em_flush,
    output logic       push_pc,
    output logic       push_flags,
    output logic       pop_flags,
    output logic       int_ack,
    output logic       in_isr,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        S_RESET      = 3'd0,
        S_RUN        = 3'd1,
        S_DRAIN      = 3'd2,
        S_PUSH_PC    = 3'd3,
        S_PUSH_FLAGS = 3'd4,
        S_VECTOR     = 3'd5,
        S_RTI        = 3'd6
    } state_t;

    localparam logic [1:0] PC_PLUS1  = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_MEM    = 2'b10;
    localparam logic [1:0] PC_RESET  = 2'b11;

    localparam logic [2:0] RESET_LAST = 3'(RESET_CYCLES - 1);
    localparam logic [2:0] DRAIN_LAST = 3'(DRAIN_CYCLES - 1);

    state_t     r_state;
    state_t     w_next_state;
    logic [2:0] r_cnt;
    logic [2:0] w_next_cnt;
    logic       r_int_pend;
    logic       r_in_isr;
    logic       w_hazard;

    assign w_hazard = ex_mem_read & ex_wb &
                      ((id_use1 & (id_rsrc1 == ex_rdst)) |
                       (id_use2 & (id_rsrc2 == ex_rdst)));

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_RESET;
            r_cnt      <= '0;
            r_int_pend <= 1'b0;
            r_in_isr   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
            // Acknowledge consumes the pending request; any other request latches it.
            if (r_state == S_PUSH_FLAGS)
                r_int_pend <= 1'b0;
            else if (int_req)
                r_int_pend <= 1'b1;
            if (r_state == S_VECTOR)
                r_in_isr <= 1'b1;
            else if (r_state == S_RTI)
                r_in_isr <= 1'b0;
        end
    end

    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        case (r_state)
            S_RESET: begin
                if (r_cnt == RESET_LAST) begin
                    w_next_state = S_RUN;
                    w_next_cnt   = '0;
                end else begin
                    w_next_cnt = r_cnt + 3'd1;
                end
            end
            S_RUN: begin
                if (mem_rti) begin
                    w_next_state = S_RTI;
                end else if (r_int_pend && !r_in_isr && !ex_branch_taken) begin
                    w_next_state = S_DRAIN;
                    w_next_cnt   = '0;
                end
            end
            S_DRAIN: begin
                w_next_cnt = (r_cnt >= DRAIN_LAST) ? DRAIN_LAST : r_cnt + 3'd1;
                if (r_cnt == DRAIN_LAST && !mem_busy)
                    w_next_state = S_PUSH_PC;
            end
            S_PUSH_PC:    w_next_state = S_PUSH_FLAGS;
            S_PUSH_FLAGS: w_next_state = S_VECTOR;
            S_VECTOR:     w_next_state = S_RUN;
            S_RTI:        w_next_state = S_RUN;
            default:      w_next_state = S_RUN;
        endcase
    end

    always_comb begin
        pc_select  = PC_PLUS1;
        fetch_en   = 1'b1;
        fd_en      = 1'b1;
        fd_flush   = 1'b0;
        de_flush   = 1'b0;
        em_flush   = 1'b0;
        push_pc    = 1'b0;
        push_flags = 1'b0;
        pop_flags  = 1'b0;
        int_ack    = 1'b0;
        case (r_state)
            S_RESET: begin
                pc_select = PC_RESET;
                fd_flush  = 1'b1;
                de_flush  = 1'b1;
                em_flush  = 1'b1;
            end
            S_RUN: begin
                // A taken branch squashes the stalled instruction anyway, so it wins.
                if (ex_branch_taken) begin
                    pc_select = PC_BRANCH;
                    fd_flush  = 1'b1;
                    de_flush  = 1'b1;
                end else if (w_hazard) begin
                    fetch_en = 1'b0;
                    fd_en    = 1'b0;
                    de_flush = 1'b1;
                end
            end
            S_DRAIN: begin
                fd_flush = 1'b1;
                if (ex_branch_taken) begin
                    fetch_en  = 1'b1;
                    pc_select = PC_BRANCH;
                    de_flush  = 1'b1;
                end else begin
                    fetch_en = 1'b0;
                end
            end
            S_PUSH_PC: begin
                push_pc  = 1'b1;
                fetch_en = 1'b0;
                fd_flush = 1'b1;
                de_flush = 1'b1;
            end
            S_PUSH_FLAGS: begin
                push_flags = 1'b1;
                int_ack    = 1'b1;
                fetch_en   = 1'b0;
                fd_flush   = 1'b1;
                de_flush   = 1'b1;
            end
            S_VECTOR: begin
                pc_select = PC_MEM;
                fd_flush  = 1'b1;
                de_flush  = 1'b1;
            end
            S_RTI: begin
                pop_flags = 1'b1;
                pc_select = PC_MEM;
                fd_flush  = 1'b1;
                de_flush  = 1'b1;
                em_flush  = 1'b1;
            end
            default: ;
        endcase
    end

    assign in_isr    = r_in_isr;
    assign state_dbg = r_state;

endmodule

// File: tb/tb_pipe_ctrl_seq.sv
// Directed bench for pipe_ctrl_seq: a phase-level behavioural model checked every
// cycle, plus hand-computed literal expectations for reset, stalls and interrupts.
module tb_pipe_ctrl_seq;

    localparam int RESET_CYCLES = 2;
    localparam int DRAIN_CYCLES = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       int_req;
    logic [2:0] id_rsrc1, id_rsrc2, ex_rdst;
    logic       id_use1, id_use2, ex_mem_read, ex_wb;
    logic       ex_branch_taken, mem_rti, mem_busy;
    logic [1:0] pc_select;
    logic       fetch_en, fd_en, fd_flush, de_flush, em_flush;
    logic       push_pc, push_flags, pop_flags, int_ack, in_isr;
    logic [2:0] state_dbg;

    int n_checks = 0;
    int n_pass   = 0;

    pipe_ctrl_seq #(.RESET_CYCLES(RESET_CYCLES), .DRAIN_CYCLES(DRAIN_CYCLES)) dut (
        .clk(clk), .rst(rst), .int_req(int_req),
        .id_rsrc1(id_rsrc1), .id_rsrc2(id_rsrc2), .id_use1(id_use1), .id_use2(id_use2),
        .ex_mem_read(ex_mem_read), .ex_wb(ex_wb), .ex_rdst(ex_rdst),
        .ex_branch_taken(ex_branch_taken), .mem_rti(mem_rti), .mem_busy(mem_busy),
        .pc_select(pc_select), .fetch_en(fetch_en), .fd_en(fd_en),
        .fd_flush(fd_flush), .de_flush(de_flush), .em_flush(em_flush),
        .push_pc(push_pc), .push_flags(push_flags), .pop_flags(pop_flags),
        .int_ack(int_ack), .in_isr(in_isr), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Model: where the sequencer is in its life, not how it encodes it.
    localparam int SEQ_NONE = 0, SEQ_PC = 1, SEQ_FLAGS = 2, SEQ_VEC = 3, SEQ_RTI = 4;
    int   m_reset_left = RESET_CYCLES;
    int   m_drain      = -1;
    int   m_seq        = SEQ_NONE;
    logic m_pend       = 1'b0;
    logic m_isr        = 1'b0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_reset_left <= RESET_CYCLES;
            m_drain      <= -1;
            m_seq        <= SEQ_NONE;
            m_pend       <= 1'b0;
            m_isr        <= 1'b0;
        end else begin
            m_pend <= (m_seq == SEQ_FLAGS) ? 1'b0 : (m_pend | int_req);
            if (m_reset_left > 0) begin
                m_reset_left <= m_reset_left - 1;
            end else if (m_drain >= 0) begin
                if (m_drain == DRAIN_CYCLES - 1 && !mem_busy) begin
                    m_drain <= -1;
                    m_seq   <= SEQ_PC;
                end else if (m_drain < DRAIN_CYCLES - 1) begin
                    m_drain <= m_drain + 1;
                end
            end else begin
                case (m_seq)
                    SEQ_PC:    m_seq <= SEQ_FLAGS;
                    SEQ_FLAGS: m_seq <= SEQ_VEC;
                    SEQ_VEC:   begin m_seq <= SEQ_NONE; m_isr <= 1'b1; end
                    SEQ_RTI:   begin m_seq <= SEQ_NONE; m_isr <= 1'b0; end
                    default: begin
                        if (mem_rti) m_seq <= SEQ_RTI;
                        else if (m_pend && !m_isr && !ex_branch_taken) m_drain <= 0;
                    end
                endcase
            end
        end
    end

    // {pc_select, fetch_en, fd_en, fd_flush, de_flush, em_flush,
    //  push_pc, push_flags, pop_flags, int_ack, in_isr, state_dbg}
    function automatic logic [14:0] model_out();
        logic [1:0] pc;
        logic fe, fde, ff, df, ef, pp, pf, pop, ack;
        logic [2:0] st;
        logic hazard;
        hazard = ex_mem_read && ex_wb &&
                 ((id_use1 && id_rsrc1 == ex_rdst) || (id_use2 && id_rsrc2 == ex_rdst));
        {pc, fe, fde, ff, df, ef, pp, pf, pop, ack} = {2'd0, 1'b1, 1'b1, 7'd0};
        if (m_reset_left > 0) begin
            st = 3'd0; pc = 2'd3; ff = 1; df = 1; ef = 1;
        end else if (m_drain >= 0) begin
            st = 3'd2; ff = 1;
            if (ex_branch_taken) begin pc = 2'd1; df = 1; end
            else fe = 0;
        end else if (m_seq == SEQ_PC) begin
            st = 3'd3; pp = 1; fe = 0; ff = 1; df = 1;
        end else if (m_seq == SEQ_FLAGS) begin
            st = 3'd4; pf = 1; ack = 1; fe = 0; ff = 1; df = 1;
        end else if (m_seq == SEQ_VEC) begin
            st = 3'd5; pc = 2'd2; ff = 1; df = 1;
        end else if (m_seq == SEQ_RTI) begin
            st = 3'd6; pop = 1; pc = 2'd2; ff = 1; df = 1; ef = 1;
        end else begin
            st = 3'd1;
            if (ex_branch_taken) begin pc = 2'd1; ff = 1; df = 1; end
            else if (hazard) begin fe = 0; fde = 0; df = 1; end
        end
        return {pc, fe, fde, ff, df, ef, pp, pf, pop, ack, m_isr, st};
    endfunction

    always @(negedge clk) begin
        check("cycle_outputs",
              {17'd0, pc_select, fetch_en, fd_en, fd_flush, de_flush, em_flush,
               push_pc, push_flags, pop_flags, int_ack, in_isr, state_dbg},
              {17'd0, model_out()});
    end

    task automatic clear_inputs();
        int_req = 0; id_rsrc1 = 0; id_rsrc2 = 0; id_use1 = 0; id_use2 = 0;
        ex_mem_read = 0; ex_wb = 0; ex_rdst = 0; ex_branch_taken = 0;
        mem_rti = 0; mem_busy = 0;
    endtask

    task automatic next_drive();
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int exp_st [7];
        int busy_st [5];
        bit found;
        exp_st  = '{2, 2, 2, 3, 4, 5, 1};
        busy_st = '{2, 2, 2, 2, 3};
        rst = 1'b0;
        clear_inputs();

        // Reset and release.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_state", state_dbg, 0);
        check("rst_pc_select", pc_select, 3);
        check("rst_flushes", {fd_flush, de_flush, em_flush, fetch_en, fd_en}, 5'b11111);
        rst = 1'b1;
        @(negedge clk);
        check("rst_cycle2_state", state_dbg, 0);
        check("rst_cycle2_pc", pc_select, 3);
        @(negedge clk);
        check("run_state", state_dbg, 1);
        check("run_defaults", {pc_select, fetch_en, fd_en, fd_flush, de_flush, em_flush},
              7'b0011000);

        // Load-use on Rsrc2.
        next_drive();
        ex_mem_read = 1; ex_wb = 1; ex_rdst = 3; id_rsrc2 = 3; id_use2 = 1;
        @(negedge clk);
        check("lu_stall", {fetch_en, fd_en, de_flush}, 3'b001);
        next_drive();
        ex_mem_read = 0;
        @(negedge clk);
        check("lu_cleared", {fetch_en, fd_en, de_flush}, 3'b110);
        next_drive();
        ex_mem_read = 1; id_use2 = 0;
        @(negedge clk);
        check("lu_unused_src", {fetch_en, fd_en, de_flush}, 3'b110);
        next_drive();
        id_use1 = 1; id_rsrc1 = 3;
        @(negedge clk);
        check("lu_src1_stall", {fetch_en, fd_en, de_flush}, 3'b001);
        next_drive();
        ex_wb = 0;
        @(negedge clk);
        check("lu_no_wb", {fetch_en, fd_en, de_flush}, 3'b110);

        // Branch overrides stall.
        next_drive();
        ex_wb = 1; ex_branch_taken = 1;
        @(negedge clk);
        check("br_over_stall", {pc_select, fetch_en, fd_en, fd_flush, de_flush}, 6'b011111);

        // Interrupt entry.
        next_drive();
        clear_inputs();
        int_req = 1;
        next_drive();
        int_req = 0;
        @(negedge clk);
        check("entry_pending_run", state_dbg, 1);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            check($sformatf("entry_state[%0d]", i), state_dbg, exp_st[i]);
            check($sformatf("entry_ack[%0d]", i), int_ack, (i == 4) ? 1 : 0);
        end
        check("entry_in_isr", in_isr, 1);

        // No nesting, then RTI re-enables the held request.
        next_drive();
        int_req = 1;
        next_drive();
        int_req = 0;
        @(negedge clk);
        check("nest_blocked", state_dbg, 1);
        next_drive();
        mem_rti = 1;
        next_drive();
        mem_rti = 0;
        @(negedge clk);
        check("rti_state", state_dbg, 6);
        check("rti_outputs", {pop_flags, pc_select, fd_flush, de_flush, em_flush}, 6'b110111);
        @(negedge clk);
        check("rti_isr_clear", {in_isr, state_dbg}, 4'b0001);
        @(negedge clk);
        check("rti_then_drain", state_dbg, 2);

        // Drain extended by mem_busy, then reset while pushing the PC.
        for (int i = 0; i < 5; i++) begin
            next_drive();
            if (i == 0) mem_busy = 1;
            if (i == 3) mem_busy = 0;
            @(negedge clk);
            check($sformatf("busy_state[%0d]", i), state_dbg, busy_st[i]);
        end
        #2 rst = 1'b0;
        #1;
        check("mid_rst_state", state_dbg, 0);
        check("mid_rst_push", push_pc, 0);
        check("mid_rst_pc", pc_select, 3);
        @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        check("pend_discarded", state_dbg, 1);

        // A taken branch delays entry by one cycle; branch during drain.
        next_drive();
        int_req = 1;
        next_drive();
        int_req = 0; ex_branch_taken = 1;
        @(negedge clk);
        check("delay_br_state", {pc_select, state_dbg}, 5'b01001);
        next_drive();
        ex_branch_taken = 0;
        @(negedge clk);
        check("delay_still_run", state_dbg, 1);
        next_drive();
        ex_branch_taken = 1;
        @(negedge clk);
        check("drain_branch",
              {state_dbg, pc_select, fetch_en, fd_flush, de_flush}, 8'b010_01_111);
        next_drive();
        ex_branch_taken = 0;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (state_dbg == 3'd1) found = 1;
        end
        check("delay_entry_done", {found, in_isr}, 2'b11);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl_seq.md
# pipe_ctrl_seq

Pipeline control sequencer for the 5-stage core: it owns PC source selection, the stage-buffer enable/flush lines, and the multi-cycle interrupt entry/exit sequence. It sits beside the decode stage, observing ID/EX and EX/MEM hazard information. It drives the fetch stage (`pc_select`, PC update enable), the fetch/decode, decode/ALU and ALU/mem buffers (enable/flush), and the memory stage's stack-push/pop requests.

## Interface
- `RESET_CYCLES`, 2: cycles spent in S_RESET after `rst` deasserts (≥1).
- `DRAIN_CYCLES`, 3: bubble cycles inserted before an interrupt push (≥1).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `int_req` in 1: external interrupt, level-sensitive.
- `id_rsrc1`, `id_rsrc2` in 3 each: source registers of the instruction in decode.
- `id_use1`, `id_use2` in 1 each: the decode instruction reads Rsrc1 / Rsrc2.
- `ex_mem_read` in 1: the instruction in execute is a load.
- `ex_wb` in 1: the execute instruction writes back.
- `ex_rdst` in 3: the execute instruction's destination.
- `ex_branch_taken` in 1: a taken branch or jump resolved in execute.
- `mem_rti` in 1: RTI is in the memory stage.
- `mem_busy` in 1: the memory stage is performing a stack access this cycle.
- `pc_select` out 2: 00 PC+1, 01 branch target, 10 memory word (vector/return), 11 reset vector.
- `fetch_en` out 1: PC register update enable.
- `fd_en` out 1: fetch/decode buffer enable.
- `fd_flush`, `de_flush`, `em_flush` out 1 each: bubble injection into the F/D, D/E and E/M buffers.
- `push_pc`, `push_flags`, `pop_flags` out 1 each: memory-stage stack requests.
- `int_ack` out 1: one-cycle pulse when the interrupt is accepted.
- `in_isr` out 1: ISR active.
- `state_dbg` out 3: current state encoding.

## Operation
- States: S_RESET=0, S_RUN=1, S_DRAIN=2, S_PUSH_PC=3, S_PUSH_FLAGS=4, S_VECTOR=5, S_RTI=6. Codes 7 and any other unused code go to S_RUN.
- Registers: `state`, 3-bit `cnt`, `int_pend`, `in_isr`.
- `int_pend` is set in any cycle where `int_req`=1. It is cleared only in the `int_ack` cycle.
- Default outputs: `pc_select`=00, `fetch_en`=1, `fd_en`=1. All other outputs are 0.

S_RESET
- Outputs: `pc_select`=11; `fd_flush`, `de_flush`, `em_flush`=1.
- `cnt` increments each cycle. When `cnt`==RESET_CYCLES-1, go to S_RUN and clear `cnt`.

S_RUN
- Transition priority: (1) `mem_rti` → S_RTI. (2) `int_pend` & !`in_isr` & !`ex_branch_taken` → S_DRAIN, with `cnt`=0.
- Combinational outputs, same cycle:
  - Branch flush: if `ex_branch_taken`, then `pc_select`=01, `fd_flush`=1, `de_flush`=1.
  - Load-use stall: the hazard term is `ex_mem_read` & `ex_wb` & ((`id_use1` & `id_rsrc1`==`ex_rdst`) | (`id_use2` & `id_rsrc2`==`ex_rdst`)).
  - If the hazard term is true and there is no taken branch, then `fetch_en`=0, `fd_en`=0, `de_flush`=1.
  - A taken branch overrides the stall.

S_DRAIN
- Outputs: `fetch_en`=0, `fd_flush`=1.
- If `ex_branch_taken`: `fetch_en`=1, `pc_select`=01, `de_flush`=1. The PC then holds the branch target, which becomes the return address.
- `cnt` increments, saturating at DRAIN_CYCLES-1.
- Go to S_PUSH_PC when `cnt`==DRAIN_CYCLES-1 and !`mem_busy`. Otherwise stay.

S_PUSH_PC
- Outputs: `push_pc`=1, `fetch_en`=0, `fd_flush`=1, `de_flush`=1.
- Go to S_PUSH_FLAGS.

S_PUSH_FLAGS
- Outputs: `push_flags`=1, `int_ack`=1, `fetch_en`=0, `fd_flush`=1, `de_flush`=1.
- Clear `int_pend`. Go to S_VECTOR.

S_VECTOR
- Outputs: `pc_select`=10, `fd_flush`=1, `de_flush`=1.
- Set `in_isr`. Go to S_RUN.

S_RTI
- Outputs: `pop_flags`=1, `pc_select`=10; `fd_flush`, `de_flush`, `em_flush`=1.
- Clear `in_isr`. Go to S_RUN.

Rules
- No nesting: while `in_isr`=1, `int_req` only sets `int_pend`. The interrupt is taken on the first S_RUN cycle after RTI.
- `mem_rti` in any state other than S_RUN is ignored.

## Timing
- While `rst`=0: `state`=S_RESET, `cnt`=0, `int_pend`=0, `in_isr`=0.
- Outputs during reset are the S_RESET decode: `pc_select`=11, `fetch_en`=1, `fd_en`=1, the three flushes=1, all other outputs 0, `state_dbg`=0.
- S_RESET lasts exactly RESET_CYCLES rising edges after `rst` rises.
- Hazard stall and branch flush are combinational, in the same cycle as their inputs.
- A load-use hazard lasts one cycle. The load advances, so the term self-clears the next cycle.
- Interrupt latency: `int_req` is sampled at edge N. S_DRAIN starts at N+1. With DRAIN_CYCLES=3 and `mem_busy`=0, the sequence runs:
  - `push_pc` at N+4
  - `push_flags`/`int_ack` at N+5
  - `pc_select`=10 at N+6
  - `in_isr`=1 from N+7
- A taken branch in the S_RUN cycle that would start an interrupt delays entry by one cycle.
- Reset asserted in any state returns the block to S_RESET immediately. Pending interrupts are discarded.

## Test plan
- Reset: hold `rst`=0 for 3 cycles, then release. Expect `pc_select`=11 and the flushes high for exactly 2 cycles, then `state_dbg`=1 with all defaults.
- Load-use: `ex_mem_read`=1, `ex_wb`=1, `ex_rdst`=3, `id_rsrc2`=3, `id_use2`=1. Expect `fetch_en`=0, `fd_en`=0, `de_flush`=1 that cycle only. Repeat with `id_use2`=0: expect no stall.
- Branch vs. stall: apply the hazard and `ex_branch_taken`=1 together. Expect `pc_select`=01, `fd_flush`=1, `de_flush`=1, `fetch_en`=1.
- Interrupt entry: pulse `int_req` for 1 cycle in S_RUN. Expect the state order 2,2,2,3,4,5,1. Expect `int_ack` high only in state 4 and `in_isr`=1 afterwards. With `mem_busy`=1 for 2 extra cycles, S_DRAIN is extended by 2.
- Nesting/RTI: with `in_isr`=1, raise `int_req`, then assert `mem_rti`. Expect S_RTI with `pop_flags`=1, `pc_select`=10 and all flushes, then `in_isr`=0, then S_DRAIN on the next cycle.
- Reset mid-sequence: drop `rst` while in S_PUSH_PC. Expect `state_dbg`=0 asynchronously, `int_pend`=0, `push_pc`=0.
